// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/opcode widths and opcode encodings.
// Both the ALU and its input loader import this package.
package alu_pkg;

    localparam int unsigned ALU_NB_DATA = 4;
    localparam int unsigned ALU_NB_OP   = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    // The ALU powers up on a well-defined opcode.
    localparam logic [5:0] OP_RESET = OP_ADD;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, counter-based debouncer and rising-edge press detector
// for one asynchronous push-button.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          st_q, st_d;
    logic          st_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any return to the stable level before the count completes restarts it.
    always_comb begin
        st_d  = st_q;
        cnt_d = '0;
        if (sync2_q != st_q) begin
            if (cnt_q == CNT_MAX) begin
                st_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            st_q     <= 1'b0;
            st_dly_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= i_btn;
            sync2_q  <= sync1_q;
            st_q     <= st_d;
            st_dly_q <= st_q;
            cnt_q    <= cnt_d;
        end
    end

    assign o_press = st_q & ~st_dly_q;

endmodule

// File: rtl/alu_input_loader.sv
// Loads ALU operands A/B and the opcode from synchronised switches on debounced
// button presses; all outputs are registered so the ALU sees stable values.
module alu_input_loader
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA         = ALU_NB_DATA,
    parameter int unsigned NB_OP           = ALU_NB_OP,
    parameter int unsigned NB_SW           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_SW-1:0]   i_sw,
    input  logic               i_btn_a,
    input  logic               i_btn_b,
    input  logic               i_btn_op,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_load_pulse,
    output logic [2:0]         o_loaded
);

    logic [NB_SW-1:0]   sw_sync1_q, sw_sync2_q;
    logic               press_a, press_b, press_op;
    logic [NB_DATA-1:0] dato_a_q, dato_a_d, dato_b_q, dato_b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic               pulse_q, pulse_d;
    logic [2:0]         loaded_q, loaded_d;
    logic               unused_sw;

    // Switch bits above the widest field are synchronised but never consumed.
    assign unused_sw = ^sw_sync2_q;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_btn  (i_btn_a),
        .o_press(press_a)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_btn  (i_btn_b),
        .o_press(press_b)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_btn  (i_btn_op),
        .o_press(press_op)
    );

    always_comb begin
        dato_a_d = dato_a_q;
        dato_b_d = dato_b_q;
        op_d     = op_q;
        loaded_d = loaded_q;
        pulse_d  = press_a | press_b | press_op;
        if (press_a) begin
            dato_a_d    = sw_sync2_q[NB_DATA-1:0];
            loaded_d[0] = 1'b1;
        end
        if (press_b) begin
            dato_b_d    = sw_sync2_q[NB_DATA-1:0];
            loaded_d[1] = 1'b1;
        end
        if (press_op) begin
            op_d        = sw_sync2_q[NB_OP-1:0];
            loaded_d[2] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            dato_a_q   <= '0;
            dato_b_q   <= '0;
            op_q       <= NB_OP'(OP_RESET);
            pulse_q    <= 1'b0;
            loaded_q   <= 3'b000;
        end else begin
            sw_sync1_q <= i_sw;
            sw_sync2_q <= sw_sync1_q;
            dato_a_q   <= dato_a_d;
            dato_b_q   <= dato_b_d;
            op_q       <= op_d;
            pulse_q    <= pulse_d;
            loaded_q   <= loaded_d;
        end
    end

    assign o_datoA      = dato_a_q;
    assign o_datoB      = dato_b_q;
    assign o_operation  = op_q;
    assign o_load_pulse = pulse_q;
    assign o_loaded     = loaded_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// Scoreboard bench for alu_input_loader: stimulus pushes expected loads (value and
// arrival cycle), a monitor pops one entry per observed load pulse.
module tb_alu_input_loader;

    localparam int DC  = 4;
    localparam int LAT = DC + 3;  // drive at negedge -> pulse seen after this many posedges

    logic       clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_sw;
    logic       i_btn_a, i_btn_b, i_btn_op;
    logic [3:0] o_datoA, o_datoB;
    logic [5:0] o_operation;
    logic       o_load_pulse;
    logic [2:0] o_loaded;

    alu_input_loader #(
        .NB_DATA        (4),
        .NB_OP          (6),
        .NB_SW          (8),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_sw        (i_sw),
        .i_btn_a     (i_btn_a),
        .i_btn_b     (i_btn_b),
        .i_btn_op    (i_btn_op),
        .o_datoA     (o_datoA),
        .o_datoB     (o_datoB),
        .o_operation (o_operation),
        .o_load_pulse(o_load_pulse),
        .o_loaded    (o_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [5:0]  op;
        logic [2:0]  ld;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          pushes = 0;
    int unsigned cyc = 0;
    logic [3:0]  m_a;
    logic [3:0]  m_b;
    logic [5:0]  m_op;
    logic [2:0]  m_ld;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_a  = 4'h0;
        m_b  = 4'h0;
        m_op = 6'b100000;
        m_ld = 3'b000;
    endtask

    task automatic push_exp();
        exp_t e;
        e.cyc = cyc + LAT;
        e.a   = m_a;
        e.b   = m_b;
        e.op  = m_op;
        e.ld  = m_ld;
        sb.push_back(e);
        pushes++;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_A"}, 32'(o_datoA), 32'(m_a));
        chk({tag, "_B"}, 32'(o_datoB), 32'(m_b));
        chk({tag, "_op"}, 32'(o_operation), 32'(m_op));
        chk({tag, "_loaded"}, 32'(o_loaded), 32'(m_ld));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        idle(3);
        model_reset();
        chk("reset_pulse", 32'(o_load_pulse), 32'd0);
        check_state("reset");
        i_rst    = 1'b0;
        i_btn_a  = 1'b0;
        i_btn_b  = 1'b0;
        i_btn_op = 1'b0;
    endtask

    // Monitor: every load pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (o_load_pulse === 1'b1) begin
                pulses++;
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("load_cycle", cyc, e.cyc);
                    chk("load_value", {14'd0, o_datoA, o_datoB, o_operation, o_loaded},
                        {14'd0, e.a, e.b, e.op, e.ld});
                end
            end
        end
    end

    initial begin
        i_rst    = 1'b1;
        i_sw     = 8'hFF;
        i_btn_a  = 1'b1;
        i_btn_b  = 1'b1;
        i_btn_op = 1'b1;
        model_reset();

        // 1: reset with switches and buttons all high
        do_reset();
        i_sw = 8'h00;
        idle(12);
        check_state("post_reset");

        // 2: single A load
        @(negedge clk);
        i_sw    = 8'h35;
        i_btn_a = 1'b1;
        m_a     = 4'h5;
        m_ld    = m_ld | 3'b001;
        push_exp();
        idle(12);
        check_state("single_a");
        i_btn_a = 1'b0;
        idle(12);
        check_state("release_a");

        // 3: bouncing B button, then a clean hold
        @(negedge clk);
        i_sw = 8'h9A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_btn_b = (i % 2 == 0);
        end
        @(negedge clk);
        i_btn_b = 1'b1;
        m_b     = 4'hA;
        m_ld    = m_ld | 3'b010;
        push_exp();
        idle(12);
        check_state("bounce_b");
        i_btn_b = 1'b0;
        idle(12);

        // 4: held op button, switches change during the hold
        @(negedge clk);
        i_sw     = 8'h26;
        i_btn_op = 1'b1;
        m_op     = 6'b100110;
        m_ld     = m_ld | 3'b100;
        push_exp();
        idle(50);
        i_sw = 8'h22;
        idle(20);
        check_state("held_op");
        i_btn_op = 1'b0;
        idle(12);
        check_state("release_op");

        // 5: simultaneous A and B presses after a fresh reset
        do_reset();
        idle(4);
        @(negedge clk);
        i_sw    = 8'h0C;
        i_btn_a = 1'b1;
        i_btn_b = 1'b1;
        m_a     = 4'hC;
        m_b     = 4'hC;
        m_ld    = 3'b011;
        push_exp();
        idle(12);
        check_state("simul_ab");
        i_btn_a = 1'b0;
        i_btn_b = 1'b0;
        idle(12);

        // 6: reset lands on edge 3 of a held A press
        @(negedge clk);
        i_sw    = 8'h07;
        i_btn_a = 1'b1;
        idle(3);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        model_reset();
        chk("rst_mid_A", 32'(o_datoA), 32'd0);
        chk("rst_mid_loaded", 32'(o_loaded), 32'd0);
        m_a  = 4'h7;
        m_ld = 3'b001;
        push_exp();
        idle(12);
        check_state("rst_mid_reload");
        i_btn_a = 1'b0;
        idle(12);

        // Drain: bounded wait for any outstanding expectation
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("pulse_count", 32'(pulses), 32'(pushes));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_input_loader.md
Name: alu_input_loader

Overview:
Front-end stage that drives the ALU operand and opcode inputs from board switches and three push-buttons.
- Synchronises and debounces each button.
- On each accepted press, latches the synchronised switch value into the A, B or operation register.
- Registered outputs connect straight to the ALU's datoA / datoB / operation inputs, so the ALU always sees stable operands.

Parameters:
NB_DATA, 4, operand width (A, B)
NB_OP, 6, opcode width
NB_SW, 8, switch bus width; must be >= max(NB_DATA, NB_OP)
DEBOUNCE_CYCLES, 500000, cycles a synchronised button level must hold before it is accepted; must be >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_sw  input  NB_SW  switch bus, asynchronous to clk
i_btn_a  input  1  load-A button, asynchronous, active-high
i_btn_b  input  1  load-B button, asynchronous, active-high
i_btn_op  input  1  load-operation button, asynchronous, active-high
o_datoA  output  NB_DATA  latched operand A
o_datoB  output  NB_DATA  latched operand B
o_operation  output  NB_OP  latched opcode
o_load_pulse  output  1  one-cycle strobe: a register was updated this cycle
o_loaded  output  3  sticky flags {op, B, A}; set on first load since reset

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and i_rst.
- Reset values:
  - o_datoA = 0, o_datoB = 0.
  - o_operation = OP_ADD (6'b100000), so the ALU never starts on an undefined opcode.
  - o_load_pulse = 0, o_loaded = 3'b000.
  - All synchroniser flops, debounce counters and stable levels = 0.
- Synchronisation: i_sw and each button pass through a 2-flop synchroniser. All downstream logic uses only the synchronised copies.
- Debounce, per button, with stable level `st` and counter `cnt`:
  - sync == st: cnt <= 0.
  - sync != st and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync != st and cnt == DEBOUNCE_CYCLES-1: st <= sync, cnt <= 0.
  - Any bounce back to st before the count completes restarts the count.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it never wraps.
- Press detect: press = st & ~st_d, where st_d is st delayed one cycle. Releases produce no action.
- Load actions on a press:
  - A press: o_datoA <= sw_sync[NB_DATA-1:0].
  - B press: o_datoB <= sw_sync[NB_DATA-1:0].
  - Op press: o_operation <= sw_sync[NB_OP-1:0].
  - The matching o_loaded bit is set and stays set until reset.
- Latency: the pin is first sampled high at edge 0 and held. st rises at edge DEBOUNCE_CYCLES+1. The register and o_load_pulse update at edge DEBOUNCE_CYCLES+2.
- o_load_pulse is high for exactly one cycle after any cycle that has one or more presses. It is the OR of the three presses, registered.
- Simultaneous presses: independent registers, so all presses in the same cycle load in that cycle. This produces a single one-cycle o_load_pulse.
- Held button: loads once only. No auto-repeat until release is debounced and a new press is debounced.
- Switch changes without a press: no output change.
- Reset mid-debounce or mid-hold:
  - All state clears on the reset cycle.
  - If the button is still held after reset, it is debounced afresh and produces one new load.
- Opcode values are not range-checked. Illegal codes are passed through to the ALU.

Decomposition:
- Shared package alu_pkg holds:
  - NB_DATA and NB_OP defaults.
  - Opcode localparams: OP_ADD 100000, OP_SUB 100010, OP_AND 100100, OP_OR 100101, OP_XOR 100110, OP_SRA 000011, OP_SRL 000010, OP_NOR 100111.
  - OP_RESET = OP_ADD.
  The ALU and this block both import it.
- Sub-module button_debouncer, instantiated 3 times. It contains the 2-flop synchroniser, debounce counter, stable level and a one-cycle press output. Parameter: DEBOUNCE_CYCLES.

Test Plan:
1. Reset check (DEBOUNCE_CYCLES=4): assert i_rst with i_sw=8'hFF and all buttons high -> outputs A=0, B=0, op=6'b100000, pulse=0, loaded=000.
2. Single load (DEBOUNCE_CYCLES=4): set i_sw=8'h35, raise i_btn_a at edge 0 and hold -> o_datoA=4'h5 and o_load_pulse=1 at edge 6 only; pulse=0 at edge 7; B and op unchanged; o_loaded=001.
3. Bounce filtering (DEBOUNCE_CYCLES=4): i_btn_b toggles 1,0,1,0 per cycle, then holds 1 -> no load during toggling; exactly one load occurs 6 edges after the final rise, with B = i_sw[3:0].
4. Held button: hold i_btn_op for 50 cycles with i_sw=8'h26, then change i_sw to 8'h22 while still held -> o_operation=6'b100110 loaded once; no reload; one pulse total.
5. Simultaneous presses: i_btn_a and i_btn_b rise in the same cycle with i_sw=8'h0C -> A=B=4'hC in the same cycle; single one-cycle pulse; o_loaded=011.
6. Reset mid-operation: assert i_rst at edge 3 of a held i_btn_a press and release reset at edge 4 with the button still held -> A stays 0 through reset; a new load occurs 6 edges after the first post-reset edge.
